// File: rtl/calc_sequencer.sv
// calc_sequencer: FIFO-buffered instruction issuer for simple_calculator; define CALC_SEQ_STICKY_CARRY_EN for a sticky carry_flag
module calc_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [25:0] in_instr,
  output logic        WEN,
  output logic [2:0]  RW,
  output logic [2:0]  RX,
  output logic [2:0]  RY,
  output logic [7:0]  DataIn,
  output logic        Sel,
  output logic [3:0]  Ctrl,
  input  logic        Carry,
  output logic        carry_flag,
  output logic        busy,
  output logic [15:0] issue_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, ISSUE} state_e;
  state_e        state_q, state_d;
  logic [25:0]   mem_q [DEPTH];
  logic [25:0]   head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [22:0]   cur_q, cur_d;
  logic [2:0]    rem_q, rem_d;
  logic          carry_q, carry_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          full, empty, push, pop, issuing, repeating, capture;
  assign head       = mem_q[rd_ptr_q];
  assign full       = count_q == (AW+1)'(DEPTH);
  assign empty      = count_q == '0;
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign issuing    = state_q == ISSUE;
  assign repeating  = issuing && rem_q != '0;
  assign pop        = !empty && !repeating;
  assign capture    = issuing && cur_q[22:20] == 3'b000;
  assign Ctrl       = issuing ? cur_q[22:19] : '0;
  assign Sel        = issuing && cur_q[18];
  assign WEN        = issuing && cur_q[17];
  assign RW         = issuing ? cur_q[16:14] : '0;
  assign RX         = issuing ? cur_q[13:11] : '0;
  assign RY         = issuing ? cur_q[10:8] : '0;
  assign DataIn     = issuing ? cur_q[7:0] : '0;
  assign busy       = issuing || !empty;
  assign carry_flag = carry_q;
  assign issue_cnt  = cnt_q;
  // next-state: FIFO bookkeeping, issue register reload or repeat countdown, status updates
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    state_d  = (pop || repeating) ? ISSUE : IDLE;
    cur_d    = pop ? {head[25:11], head[7:0]} : cur_q;
    rem_d    = pop ? head[10:8] : repeating ? rem_q - 3'd1 : rem_q;
`ifdef CALC_SEQ_STICKY_CARRY_EN
    carry_d  = capture ? (carry_q | Carry) : carry_q;
`else
    carry_d  = capture ? Carry : carry_q;
`endif
    cnt_d    = WEN ? cnt_q + 16'd1 : cnt_q;
  end
  // FIFO storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= in_instr;
  end
  // state registers with asynchronous reset
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cur_q    <= '0;
      rem_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cur_q    <= cur_d;
      rem_q    <= rem_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed self-checking bench for calc_sequencer
module tb_calc_sequencer;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, carry = 1'b0;
  logic [25:0] in_instr = '0;
  logic        in_ready, wen, sel, carry_flag, busy;
  logic [2:0]  rw, rx, ry;
  logic [7:0]  data_in;
  logic [3:0]  ctrl;
  logic [15:0] issue_cnt;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  calc_sequencer #(.DEPTH(4)) dut (
    .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .WEN(wen), .RW(rw), .RX(rx), .RY(ry), .DataIn(data_in), .Sel(sel), .Ctrl(ctrl),
    .Carry(carry), .carry_flag(carry_flag), .busy(busy), .issue_cnt(issue_cnt)
  );

  function automatic logic [25:0] mk(input logic [3:0] c, input logic s, input logic w,
                                     input logic [2:0] a, input logic [2:0] x, input logic [2:0] y,
                                     input logic [2:0] rep, input logic [7:0] d);
    return {c, s, w, a, x, y, rep, d};
  endfunction

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; carry = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b exp 1", in_ready); end
    tests++; if (issue_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d exp 0", issue_cnt); end
    tests++; if (wen !== 1'b0) begin fails++; $display("FAIL reset_wen: got %b exp 0", wen); end
    in_valid = 1'b1; in_instr = mk(4'b0010, 1'b0, 1'b1, 3'd2, 3'd0, 3'd0, 3'd7, 8'h11);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    tests++; if (wen !== 1'b1) begin fails++; $display("FAIL midissue_wen: got %b exp 1", wen); end
    #2 rst = 1'b1;
    #1;
    tests++; if (wen !== 1'b0) begin fails++; $display("FAIL async_reset_wen: got %b exp 0", wen); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy: got %b exp 0", busy); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b exp 1", in_ready); end
    tests++; if (issue_cnt !== 16'd0) begin fails++; $display("FAIL post_reset_cnt: got %0d exp 0", issue_cnt); end
    tests++; if (carry_flag !== 1'b0) begin fails++; $display("FAIL post_reset_carry: got %b exp 0", carry_flag); end
    tests++; if (wen !== 1'b0) begin fails++; $display("FAIL post_reset_wen: got %b exp 0", wen); end
  endtask

  task automatic test_single;
    in_valid = 1'b1; in_instr = mk(4'b0000, 1'b0, 1'b1, 3'd1, 3'd0, 3'd1, 3'd0, 8'h05);
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (wen !== 1'b0) begin fails++; $display("FAIL single_pre_wen: got %b exp 0", wen); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_pre_busy: got %b exp 1", busy); end
    @(negedge clk);
    tests++; if (wen !== 1'b1) begin fails++; $display("FAIL single_wen: got %b exp 1", wen); end
    tests++; if (rw !== 3'd1) begin fails++; $display("FAIL single_rw: got %0d exp 1", rw); end
    tests++; if (ry !== 3'd1) begin fails++; $display("FAIL single_ry: got %0d exp 1", ry); end
    tests++; if (data_in !== 8'h05) begin fails++; $display("FAIL single_data: got %h exp 05", data_in); end
    tests++; if (ctrl !== 4'b0000 || sel !== 1'b0) begin fails++; $display("FAIL single_ctrl_sel: got %b/%b exp 0000/0", ctrl, sel); end
    @(negedge clk);
    tests++; if (wen !== 1'b0) begin fails++; $display("FAIL single_post_wen: got %b exp 0", wen); end
    tests++; if (data_in !== 8'h00) begin fails++; $display("FAIL single_post_data: got %h exp 00", data_in); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_post_busy: got %b exp 0", busy); end
    tests++; if (issue_cnt !== 16'd1) begin fails++; $display("FAIL single_cnt: got %0d exp 1", issue_cnt); end
  endtask

  task automatic test_repeat;
    logic [15:0] base;
    base = issue_cnt;
    in_valid = 1'b1; in_instr = mk(4'b0011, 1'b1, 1'b1, 3'd3, 3'd3, 3'd2, 3'd3, 8'hA5);
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (wen !== 1'b0) begin fails++; $display("FAIL repeat_pre_wen: got %b exp 0", wen); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (wen !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL repeat_wen_busy[%0d]: got %b/%b exp 1/1", i, wen, busy); end
      tests++; if ({ctrl, sel, rw, rx, ry, data_in} !== {4'b0011, 1'b1, 3'd3, 3'd3, 3'd2, 8'hA5}) begin
        fails++; $display("FAIL repeat_fields[%0d]: got %h/%b/%0d/%0d/%0d/%h exp 3/1/3/3/2/a5", i, ctrl, sel, rw, rx, ry, data_in);
      end
    end
    @(negedge clk);
    tests++; if (wen !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL repeat_end: got wen %b busy %b exp 0/0", wen, busy); end
    tests++; if (issue_cnt !== base + 16'd4) begin fails++; $display("FAIL repeat_cnt: got %0d exp %0d", issue_cnt, base + 16'd4); end
  endtask

  task automatic test_back_to_back;
    logic [25:0] w [5];
    logic [7:0]  exp_d;
    logic        exp_w, exp_r;
    logic [15:0] base;
    base = issue_cnt;
    w[0] = mk(4'b0010, 1'b0, 1'b1, 3'd1, 3'd0, 3'd0, 3'd7, 8'h10);
    for (int i = 1; i < 5; i++) w[i] = mk(4'b0010, 1'b0, 1'b1, 3'(i), 3'd0, 3'd0, 3'd0, 8'(8'h20 + i));
    in_valid = 1'b1; in_instr = w[0];
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_w = k >= 2 && k <= 13;
      exp_r = !(k >= 5 && k <= 9);
      exp_d = (k >= 2 && k <= 9) ? 8'h10 : (k >= 10 && k <= 13) ? 8'(8'h20 + k - 9) : 8'h00;
      tests++; if (in_ready !== exp_r) begin fails++; $display("FAIL b2b_ready[%0d]: got %b exp %b", k, in_ready, exp_r); end
      tests++; if (wen !== exp_w || data_in !== exp_d) begin fails++; $display("FAIL b2b_issue[%0d]: got wen %b data %h exp %b %h", k, wen, data_in, exp_w, exp_d); end
      tests++; if (busy !== (k <= 13)) begin fails++; $display("FAIL b2b_busy[%0d]: got %b exp %b", k, busy, k <= 13); end
      in_valid = k <= 4;
      in_instr = (k <= 4) ? w[k] : '0;
    end
    tests++; if (issue_cnt !== base + 16'd12) begin fails++; $display("FAIL b2b_cnt: got %0d exp %0d", issue_cnt, base + 16'd12); end
  endtask

  task automatic test_carry;
    logic [25:0] w [3];
    logic        exp_c;
    w[0] = mk(4'b0000, 1'b0, 1'b1, 3'd1, 3'd0, 3'd1, 3'd0, 8'h01);
    w[1] = mk(4'b0010, 1'b0, 1'b1, 3'd2, 3'd0, 3'd1, 3'd0, 8'h02);
    w[2] = mk(4'b0000, 1'b0, 1'b1, 3'd3, 3'd0, 3'd1, 3'd0, 8'h03);
    in_valid = 1'b1; in_instr = w[0]; carry = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
`ifdef CALC_SEQ_STICKY_CARRY_EN
      exp_c = k >= 3;
`else
      exp_c = k == 3 || k == 4;
`endif
      tests++; if (carry_flag !== exp_c) begin fails++; $display("FAIL carry_flag[%0d]: got %b exp %b", k, carry_flag, exp_c); end
      in_valid = k <= 2;
      in_instr = (k <= 2) ? w[k] : '0;
      carry = k == 2;
    end
  endtask

  task automatic test_simul_push_pop;
    logic [25:0] w [5];
    logic [7:0]  exp_d;
    w[0] = mk(4'b0010, 1'b0, 1'b1, 3'd4, 3'd0, 3'd0, 3'd4, 8'h30);
    for (int i = 1; i < 5; i++) w[i] = mk(4'b0010, 1'b0, 1'b1, 3'd4, 3'd0, 3'd0, 3'd0, 8'(8'h30 + i));
    in_valid = 1'b1; in_instr = w[0];
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      exp_d = (k >= 2 && k <= 6) ? 8'h30 : (k >= 7 && k <= 10) ? 8'(8'h30 + k - 6) : 8'h00;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL simul_ready[%0d]: got %b exp 1", k, in_ready); end
      tests++; if (data_in !== exp_d || wen !== (exp_d != 8'h00)) begin fails++; $display("FAIL simul_issue[%0d]: got data %h wen %b exp %h", k, data_in, wen, exp_d); end
      in_valid = k <= 3 || k == 6;
      in_instr = (k <= 3) ? w[k] : (k == 6) ? w[4] : '0;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_repeat;
    test_back_to_back;
    test_carry;
    test_simul_push_pop;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Instruction sequencer placed directly upstream of `simple_calculator`. It accepts packed 26-bit calculator instructions over a valid/ready handshake and buffers them in a small FIFO. It issues each instruction to the calculator for one or more consecutive cycles and drives `WEN`/`RW`/`RX`/`RY`/`DataIn`/`Sel`/`Ctrl`. It captures the calculator's `Carry` into a status flag.

## Interface
- `DEPTH`, 4: instruction FIFO depth; power of two, at least 2.
- `Clk` input 1: single clock; all state updates on its rising edge.
- `Rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: instruction word is present on `in_instr`.
- `in_ready` output 1: FIFO can accept a word; equals `!full`.
- `in_instr` input 26: packed instruction. Fields:
  - `[25:22]` Ctrl
  - `[21]` Sel
  - `[20]` Wen
  - `[19:17]` RW
  - `[16:14]` RX
  - `[13:11]` RY
  - `[10:8]` Rep
  - `[7:0]` DataIn
- `WEN` output 1: register-file write enable to the calculator.
- `RW`, `RX`, `RY` output 3 each: register addresses to the calculator.
- `DataIn` output 8: immediate operand to the calculator.
- `Sel` output 1: calculator mux select (1 = busX, 0 = DataIn).
- `Ctrl` output 4: ALU opcode.
- `Carry` input 1: ALU carry from the calculator; combinational in the current issue cycle.
- `carry_flag` output 1: captured carry status.
- `busy` output 1: high when the FSM is in ISSUE or the FIFO is non-empty.
- `issue_cnt` output 16: count of issue cycles with `WEN`=1; wraps modulo 2^16.

## Operation
- **Push:** a word is written into the FIFO on a rising edge when `in_valid && in_ready`. While the FIFO is full, `in_ready`=0. There is no pass-through when full, even if a pop occurs in the same cycle.
- **FSM states:**
  - IDLE: all calculator outputs are 0.
  - ISSUE: calculator outputs are driven combinationally from the issue register `cur`.
- **IDLE → ISSUE:** on an edge with the FIFO non-empty. The head is popped into `cur`, and `rem` is loaded with the Rep field.
- **Each ISSUE cycle:**
  - `WEN` = `cur`.Wen. `RW`, `RX`, `RY`, `DataIn`, `Sel`, `Ctrl` come from `cur`.
  - The calculator performs its write on the edge that ends the cycle.
- **End of an ISSUE cycle with `rem` ≠ 0:** `rem` decrements. The same instruction is re-issued next cycle, operating on the freshly written register (iterated accumulate or shift).
- **End of an ISSUE cycle with `rem` = 0:**
  - FIFO non-empty: pop the next word into `cur` and stay in ISSUE, with no bubble.
  - FIFO empty: go to IDLE.
- An instruction with Rep = r occupies exactly r+1 consecutive issue cycles.
- **Carry capture:** at the edge ending an issue cycle whose `Ctrl` is 4'b0000 or 4'b0001, `carry_flag` is updated from `Carry`. Other opcodes leave `carry_flag` unchanged.
- `issue_cnt` increments at the end of every issue cycle with `WEN`=1.
- A push and a pop on the same edge are both honoured; the occupancy count is unchanged.

## Timing
- **Reset values:**
  - FSM = IDLE; FIFO empty.
  - `cur`, `rem` = 0.
  - `WEN`, `RW`, `RX`, `RY`, `DataIn`, `Sel`, `Ctrl` = 0.
  - `carry_flag` = 0, `busy` = 0, `issue_cnt` = 0, `in_ready` = 1.
- **Latency:** a word accepted at edge E0 is issued in the cycle E1–E2 when the sequencer was IDLE with an empty FIFO. The calculator register write lands at E2.
- **Throughput:** one issue cycle per clock. The FIFO drains at one word per (Rep+1) cycles.
- **Reset mid-operation:** `WEN` drops to 0 asynchronously. The FIFO contents and the in-flight instruction are discarded; no partial repeat survives.
- **Pointers:** FIFO pointers wrap modulo `DEPTH`. Full and empty are distinguished by a count register of width log2(`DEPTH`)+1.

## Configuration
- `CALC_SEQ_STICKY_CARRY_EN`
  - Defined: `carry_flag` <= `carry_flag | Carry` on capturing cycles. It is cleared only by `Rst`.
  - Undefined: `carry_flag` <= `Carry`, i.e. it holds the carry of the last add or subtract.

## Test plan
- **Reset:** assert `Rst` mid-ISSUE with `WEN`=1 → `WEN`=0 immediately. After release: `busy`=0, `in_ready`=1, `issue_cnt`=0, `carry_flag`=0.
- **Single instruction latency:** push Ctrl=0000, Sel=0, Wen=1, RW=1, RX=0, RY=1, Rep=0, DataIn=8'h05 at edge E0 → `WEN`=1, `RW`=1, `DataIn`=8'h05 during E1–E2 only, then IDLE. `issue_cnt`=1.
- **Repeat:** push Rep=3 → four consecutive identical issue cycles, with `busy` high throughout. `issue_cnt` increases by 4.
- **Back-to-back:** with `DEPTH`=4, push 5 words continuously while idle → `in_ready` drops for exactly the cycles the FIFO holds 4 words. All 5 words are issued in order with no idle cycle between them.
- **Carry:** issue add with `Carry`=1, then an AND (0010) with `Carry`=0, then add with `Carry`=0 → `carry_flag` reads 1, 1, then 0. With `CALC_SEQ_STICKY_CARRY_EN` defined, the final value is 1.
- **Simultaneous push and pop at 3 words occupancy:** occupancy is unchanged and ordering is preserved.
